// File: rtl/pcileech_iobridge_ep.sv
// Bridge-side endpoint of the IO bridge bus.
// BUS_DI words are buffered in an RX FIFO and serialized onto a 32-bit host
// stream; a 32-bit host stream is registered onto BUS_DO.
//
// state  | meaning
// IDLE   | holding register empty, waiting for the FIFO to become non-empty
// LO     | holding register's low dword waits for the output register
// HI     | holding register's high dword waits for the output register
module pcileech_iobridge_ep #(
    parameter int DEPTH            = 64,
    parameter int PROG_FULL_MARGIN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [68:0] BUS_DI,
    output logic        BUS_DI_PROG_FULL,
    output logic [36:0] BUS_DO,
    output logic [31:0] host_tx_data,
    output logic        host_tx_valid,
    input  logic        host_tx_ready,
    input  logic [31:0] host_rx_data,
    input  logic        host_rx_valid,
    output logic        host_rx_ready,
    output logic        overflow,
    output logic [15:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_THRESH = (AW+1)'(DEPTH - PROG_FULL_MARGIN);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_e;

    logic [65:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          pfull_q, ovf_q;
    logic [15:0]   drop_q;
    state_e        state_q, state_d;
    logic [65:0]   hold_q, hold_d;
    logic [31:0]   tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic [31:0]   do_data_q;
    logic          do_valid_q, rx_ready_q;

    logic        wr_req, full, empty, pop, push_ok, drop, out_free, take_next;
    logic [65:0] head;
    logic        unused_rsvd;

    assign unused_rsvd = ^BUS_DI[67:66];
    assign wr_req   = BUS_DI[68] && (BUS_DI[65:64] != 2'b00);
    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign head     = mem_q[rd_ptr_q];
    // a pop in the same cycle frees the slot, so a write to a full FIFO still lands
    assign push_ok  = wr_req && (!full || pop);
    assign drop     = wr_req && full && !pop;
    assign out_free = !tx_valid_q || host_tx_ready;

    // occupancy after this edge
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // FIFO storage, no reset needed: validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= BUS_DI[65:0];
    end

    // FIFO pointers, occupancy, backpressure and drop accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pfull_q  <= 1'b1;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q   <= cnt_d;
            pfull_q <= (cnt_d >= CNT_THRESH);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    // serializer next state; refilling the holding register in the same cycle
    // its last dword moves out keeps the stream free of bubbles
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        pop        = 1'b0;
        take_next  = 1'b0;
        if (out_free) tx_valid_d = 1'b0;
        case (state_q)
            S_IDLE: take_next = 1'b1;
            S_LO: begin
                if (out_free) begin
                    tx_data_d  = hold_q[31:0];
                    tx_valid_d = 1'b1;
                    if (hold_q[65]) state_d = S_HI;
                    else            take_next = 1'b1;
                end
            end
            S_HI: begin
                if (out_free) begin
                    tx_data_d  = hold_q[63:32];
                    tx_valid_d = 1'b1;
                    take_next  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (take_next) begin
            if (!empty) begin
                pop     = 1'b1;
                hold_d  = head;
                state_d = head[64] ? S_LO : S_HI;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // serializer state, holding register and host output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // host-to-core path: one registered BUS_DO pulse per accepted dword
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
            do_valid_q <= 1'b0;
            do_data_q  <= '0;
        end else begin
            rx_ready_q <= 1'b1;
            do_valid_q <= host_rx_valid && rx_ready_q;
            if (host_rx_valid && rx_ready_q) do_data_q <= host_rx_data;
        end
    end

    assign BUS_DI_PROG_FULL = pfull_q;
    assign BUS_DO           = {4'b0000, do_valid_q, do_data_q};
    assign host_tx_data     = tx_data_q;
    assign host_tx_valid    = tx_valid_q;
    assign host_rx_ready    = rx_ready_q;
    assign overflow         = ovf_q;
    assign drop_count       = drop_q;
endmodule

// File: tb/tb_pcileech_iobridge_ep.sv
// Self-checking bench for pcileech_iobridge_ep: expected host dwords are kept
// in a queue built from the written entries and their masks.
module tb_pcileech_iobridge_ep;
    logic        clk;
    logic        rst_n;
    logic [68:0] BUS_DI;
    logic        BUS_DI_PROG_FULL;
    logic [36:0] BUS_DO;
    logic [31:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [31:0] host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic        overflow;
    logic [15:0] drop_count;

    pcileech_iobridge_ep #(.DEPTH(64), .PROG_FULL_MARGIN(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .BUS_DI           (BUS_DI),
        .BUS_DI_PROG_FULL (BUS_DI_PROG_FULL),
        .BUS_DO           (BUS_DO),
        .host_tx_data     (host_tx_data),
        .host_tx_valid    (host_tx_valid),
        .host_tx_ready    (host_tx_ready),
        .host_rx_data     (host_rx_data),
        .host_rx_valid    (host_rx_valid),
        .host_rx_ready    (host_rx_ready),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_do;
    logic [63:0] d;
    logic [1:0]  m;
    logic        prev_stall;
    logic [31:0] prev_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void exp_push(input logic [1:0] mk, input logic [63:0] dt);
        if (mk[0]) exp_q.push_back(dt[31:0]);
        if (mk[1]) exp_q.push_back(dt[63:32]);
    endfunction

    task automatic wr(input logic [1:0] mk, input logic [63:0] dt);
        BUS_DI = {1'b1, 2'b00, mk, dt};
        step();
        BUS_DI = '0;
    endtask

    task automatic wait_drain(input int budget, input bit rnd, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (rnd) host_tx_ready = ($urandom_range(0, 2) != 0);
            step();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic tx_send(input logic v, input logic [31:0] dt);
        host_rx_valid = v;
        host_rx_data  = dt;
        step();
        if (v) last_do = dt;
        check("bus_do", BUS_DO, {27'd0, 4'b0000, v, last_do});
    endtask

    task automatic check_reset_vals();
        check("rst_prog_full", BUS_DI_PROG_FULL, 1);
        check("rst_bus_do", BUS_DO, 0);
        check("rst_tx_valid", host_tx_valid, 0);
        check("rst_tx_data", host_tx_data, 0);
        check("rst_rx_ready", host_rx_ready, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
    endtask

    // host-side monitor: ordering against the model and stability under stall
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", host_tx_valid, 1);
                check("stall_data", host_tx_data, prev_data);
            end
            if (host_tx_valid && host_tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    assert (exp_q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL extra_dword observed=%0h expected=none", host_tx_data);
                    end
                end else begin
                    check("tx_dword", host_tx_data, exp_q.pop_front());
                end
            end
            prev_stall <= host_tx_valid && !host_tx_ready;
            prev_data  <= host_tx_data;
        end
    end

    initial begin
        rst_n         = 1'b0;
        BUS_DI        = '0;
        host_tx_ready = 1'b0;
        host_rx_data  = '0;
        host_rx_valid = 1'b0;
        last_do       = '0;
        #22;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_rx_ready", host_rx_ready, 1);
        check("rel_prog_full", BUS_DI_PROG_FULL, 0);

        // host-to-core path: directed pair, idle, then random traffic
        tx_send(1'b1, 32'hDEADBEEF);
        tx_send(1'b1, 32'h00000001);
        tx_send(1'b0, 32'h55555555);
        for (int i = 0; i < 30; i++) tx_send(1'($urandom_range(0, 1)), $urandom);
        host_rx_valid = 1'b0;

        // mask handling
        host_tx_ready = 1'b1;
        wr(2'b01, 64'hAAAA_BBBB_CCCC_DDDD); exp_push(2'b01, 64'hAAAA_BBBB_CCCC_DDDD);
        wr(2'b10, 64'h1234_5678_0000_0000); exp_push(2'b10, 64'h1234_5678_0000_0000);
        wr(2'b00, 64'h9999_8888_7777_6666);
        wait_drain(50, 1'b0, "mask_drain");
        repeat (10) step();
        check("mask_idle_valid", host_tx_valid, 0);
        check("mask_no_drop", drop_count, 0);

        // backpressure: one primer entry parks in the serializer, then fill the FIFO
        host_tx_ready = 1'b0;
        wr(2'b11, 64'hC0DE_0001_C0DE_0000); exp_push(2'b11, 64'hC0DE_0001_C0DE_0000);
        repeat (3) step();
        for (int k = 1; k <= 64; k++) begin
            d = {16'hB0B0, 16'(k), 16'hA0A0, 16'(k)};
            wr(2'b11, d);
            exp_push(2'b11, d);
            check("prog_full", BUS_DI_PROG_FULL, (k >= 56) ? 1 : 0);
        end
        check("full_overflow", overflow, 0);
        check("full_drop_count", drop_count, 0);
        for (int k = 0; k < 3; k++) wr(2'b11, 64'hDEAD_0000_DEAD_0000 | 64'(k));
        check("ovf_sticky", overflow, 1);
        check("ovf_drop_count", drop_count, 3);

        // full boundary: write coincides with a pop
        host_tx_ready = 1'b1;
        wr(2'b11, 64'hFEED_0002_FEED_0001); exp_push(2'b11, 64'hFEED_0002_FEED_0001);
        host_tx_ready = 1'b0;
        check("bnd_drop_count", drop_count, 3);
        check("bnd_prog_full", BUS_DI_PROG_FULL, 1);
        wr(2'b11, 64'hBAD0_0000_BAD0_0000);
        check("bnd_still_full", drop_count, 4);

        host_tx_ready = 1'b1;
        wait_drain(400, 1'b0, "full_drain");
        repeat (5) step();
        check("drain_valid", host_tx_valid, 0);
        check("drain_prog_full", BUS_DI_PROG_FULL, 0);
        check("drain_overflow", overflow, 1);
        check("drain_drop_count", drop_count, 4);

        // reset mid-stream discards buffered data
        host_tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) wr(2'b11, {32'h7000_0000, 32'(k)});
        BUS_DI = {1'b1, 2'b00, 2'b11, 64'h7777_7777_7777_7777};
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        BUS_DI = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst2_rx_ready", host_rx_ready, 1);

        // first write after reset: latency and dword order
        wr(2'b11, 64'h1111_2222_3333_4444); exp_push(2'b11, 64'h1111_2222_3333_4444);
        check("lat_n0_valid", host_tx_valid, 0);
        step();
        check("lat_n1_valid", host_tx_valid, 0);
        step();
        check("lat_n2_valid", host_tx_valid, 1);
        check("lat_n2_data", host_tx_data, 32'h33334444);
        host_tx_ready = 1'b1;
        wait_drain(20, 1'b0, "first_drain");
        repeat (3) step();

        // random ready: 1000 incrementing two-dword entries, then random masks
        begin
            int sent = 0;
            int cyc  = 0;
            while (sent < 1200 && cyc < 40000) begin
                host_tx_ready = ($urandom_range(0, 3) != 0);
                if (!BUS_DI_PROG_FULL && $urandom_range(0, 3) != 0) begin
                    if (sent < 1000) begin
                        m = 2'b11;
                        d = {32'(2 * sent + 1), 32'(2 * sent)};
                    end else begin
                        m = 2'($urandom_range(0, 3));
                        d = {$urandom, $urandom};
                    end
                    BUS_DI = {1'b1, 2'($urandom_range(0, 3)), m, d};
                    exp_push(m, d);
                    sent++;
                end else begin
                    BUS_DI = '0;
                end
                step();
                cyc++;
            end
            BUS_DI = '0;
            check("rand_sent", sent, 1200);
        end
        wait_drain(20000, 1'b1, "rand_drain");
        host_tx_ready = 1'b1;
        repeat (5) step();
        check("rand_no_drop", drop_count, 0);
        check("rand_no_overflow", overflow, 0);
        check("rand_idle_valid", host_tx_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
